// File: rtl/apb_master.sv
// APB master bridge: accepts one request at a time from a simple valid/ready
// front end and runs it as an APB SETUP/ACCESS transfer. Returns a one-cycle
// response pulse carrying read data and an error flag. A slave that holds
// pready low too long is abandoned with an error response.
module apb_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  // Abort fires on the TIMEOUT-th waiting ACCESS cycle (counter value TIMEOUT-1).
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   wait_cnt_r;
  logic [CW-1:0]   wait_cnt_nxt_s;
  logic            psel_nxt_s;
  logic            penable_nxt_s;
  logic            resp_valid_nxt_s;
  logic [DW-1:0]   resp_rdata_nxt_s;
  logic            resp_err_nxt_s;
  logic            load_req_s;
  logic            timeout_hit_s;

  assign req_ready     = (state_r == IDLE);
  assign timeout_hit_s = TO_EN && (wait_cnt_r == TO_LAST);

  // Next-state and next-output decode; APB strobes and response are registered.
  always_comb begin
    state_nxt_s      = state_r;
    wait_cnt_nxt_s   = wait_cnt_r;
    psel_nxt_s       = 1'b0;
    penable_nxt_s    = 1'b0;
    resp_valid_nxt_s = 1'b0;
    resp_rdata_nxt_s = '0;
    resp_err_nxt_s   = 1'b0;
    load_req_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = SETUP;
          psel_nxt_s  = 1'b1;
          load_req_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s    = ACCESS;
        psel_nxt_s     = 1'b1;
        penable_nxt_s  = 1'b1;
        wait_cnt_nxt_s = '0;
      end
      ACCESS: begin
        if (pready) begin
          // Completion wins over a timeout firing in the same cycle.
          state_nxt_s      = IDLE;
          resp_valid_nxt_s = 1'b1;
          resp_rdata_nxt_s = pwrite ? '0 : prdata;
          resp_err_nxt_s   = pslverr;
        end else if (timeout_hit_s) begin
          state_nxt_s      = IDLE;
          resp_valid_nxt_s = 1'b1;
          resp_err_nxt_s   = 1'b1;
          wait_cnt_nxt_s   = wait_cnt_r + CW'(1);
        end else begin
          psel_nxt_s     = 1'b1;
          penable_nxt_s  = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, APB outputs and response registers; reset drops the bus at once.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r    <= IDLE;
      wait_cnt_r <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      psel       <= psel_nxt_s;
      penable    <= penable_nxt_s;
      resp_valid <= resp_valid_nxt_s;
      resp_rdata <= resp_rdata_nxt_s;
      resp_err   <= resp_err_nxt_s;
      if (load_req_s) begin
        paddr  <= req_addr;
        pwdata <= req_wdata;
        pwrite <= req_write;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master (TIMEOUT=4): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model of the bridge.
module tb_apb_master;

  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] paddr, pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  apb_master #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a transfer is "busy" for a known number of
  // cycles (1 setup + access cycles until pready or TO waits), then a response.
  bit          m_busy;
  int          m_cyc;
  int          m_waits;
  logic [31:0] m_addr, m_wdata;
  logic        m_write;
  logic        m_rv, m_err;
  logic [31:0] m_rd;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_busy <= 1'b0; m_cyc <= 0; m_waits <= 0;
      m_addr <= 32'h0; m_wdata <= 32'h0; m_write <= 1'b0;
      m_rv <= 1'b0; m_rd <= 32'h0; m_err <= 1'b0;
    end else begin
      m_rv <= 1'b0; m_rd <= 32'h0; m_err <= 1'b0;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy <= 1'b1; m_cyc <= 1;
          m_addr <= req_addr; m_wdata <= req_wdata; m_write <= req_write;
        end
      end else if (m_cyc == 1) begin
        m_cyc <= 2; m_waits <= 0;
      end else if (pready) begin
        m_busy <= 1'b0; m_rv <= 1'b1;
        m_rd <= m_write ? 32'h0 : prdata;
        m_err <= pslverr;
      end else if (m_waits + 1 >= TO) begin
        m_busy <= 1'b0; m_rv <= 1'b1; m_err <= 1'b1;
      end else begin
        m_waits <= m_waits + 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the reference.
  always @(negedge pclk) begin
    if (cmp_en) begin
      check("req_ready", req_ready, !m_busy);
      check("psel", psel, m_busy);
      check("penable", penable, m_busy && (m_cyc >= 2));
      check("paddr", paddr, m_addr);
      check("pwdata", pwdata, m_wdata);
      check("pwrite", pwrite, m_write);
      check("resp_valid", resp_valid, m_rv);
      if (m_rv) begin
        check("resp_rdata", resp_rdata, m_rd);
        check("resp_err", resp_err, m_err);
      end
    end
  end

  int          t_resp_cyc, t_psel, t_pen, t_ready;
  logic [31:0] t_rdata, t_addr;
  logic        t_err;
  time         t_resp_time;

  // One transfer driven from the request side with nwait low-pready ACCESS
  // cycles; returns in the response cycle (cycle 1 = SETUP after accept).
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int nwait, input logic [31:0] rd, input logic se,
                         input logic hold);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    pready = 1'b0; prdata = rd; pslverr = se;
    t_resp_cyc = -1; t_psel = 0; t_pen = 0; t_ready = 0;
    t_addr = 32'h0; t_rdata = 32'h0; t_err = 1'b0;
    @(posedge pclk); #1;
    // Keep req_valid (optionally) with junk values: must be ignored while busy.
    req_valid = hold; req_addr = ~a; req_wdata = ~d; req_write = ~w;
    for (int c = 1; c < 40; c++) begin
      pready = ((c - 2) >= nwait);
      if (resp_valid) begin
        t_resp_cyc = c; t_rdata = resp_rdata; t_err = resp_err;
        t_resp_time = $time;
        break;
      end
      if (psel) t_psel++;
      if (penable) t_pen++;
      if (req_ready) t_ready++;
      if (c == 1) t_addr = paddr;
      @(posedge pclk); #1;
    end
    pready = 1'b0;
    check("xfer_completed", (t_resp_cyc != -1), 1'b1);
  endtask

  time prev_time;
  int  rv_cnt;

  initial begin
    presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    presetn = 1'b1;
    cmp_en = 1'b1;
    @(posedge pclk); #1;

    // Write, zero wait.
    do_xfer(1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b0);
    req_valid = 1'b0;
    check("w0_resp_cycle", t_resp_cyc, 3);
    check("w0_psel_cycles", t_psel, 2);
    check("w0_penable_cycles", t_pen, 1);
    check("w0_err", t_err, 1'b0);
    check("w0_paddr", t_addr, 32'h10);
    @(posedge pclk); #1;

    // Read with 3 wait states.
    do_xfer(1'b0, 32'h04, 32'h0, 3, 32'h0000_00C3, 1'b0, 1'b0);
    req_valid = 1'b0;
    check("r3_resp_cycle", t_resp_cyc, 6);
    check("r3_rdata", t_rdata, 32'hC3);
    check("r3_err", t_err, 1'b0);
    check("r3_ready_while_busy", t_ready, 0);
    check("r3_penable_cycles", t_pen, 4);
    @(posedge pclk); #1;

    // Slave error, then next request accepted on the response cycle.
    do_xfer(1'b1, 32'h20, 32'h0000_1234, 0, 32'h0, 1'b1, 1'b0);
    check("se_err", t_err, 1'b1);
    check("se_ready_on_resp", req_ready, 1'b1);
    prev_time = t_resp_time;

    // Back-to-back with req_valid held high (first starts on the previous resp cycle).
    for (int i = 0; i < 4; i++) begin
      do_xfer(1'b1, 32'h100 + 32'(4 * i), $urandom, 0, 32'h0, 1'b0, (i < 3));
      check("b2b_resp_cycle", t_resp_cyc, 3);
      check("b2b_paddr", t_addr, 32'h100 + 32'(4 * i));
      check("b2b_spacing", t_resp_time - prev_time, 64'd30);
      prev_time = t_resp_time;
    end
    req_valid = 1'b0;
    @(posedge pclk); #1;

    // Timeout: pready never rises.
    do_xfer(1'b0, 32'h40, 32'h0, 1000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    req_valid = 1'b0;
    check("to_resp_cycle", t_resp_cyc, 6);
    check("to_access_cycles", t_pen, TO);
    check("to_err", t_err, 1'b1);
    check("to_rdata", t_rdata, 32'h0);
    @(posedge pclk); #1;
    check("to_psel_after", psel, 1'b0);

    // Mid-transfer reset during ACCESS.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h55;
    pready = 1'b0;
    @(posedge pclk); #1;
    req_valid = 1'b0;
    @(posedge pclk); #1;
    check("mr_in_access", penable, 1'b1);
    presetn = 1'b0;
    #1;
    check("mr_psel", psel, 1'b0);
    check("mr_penable", penable, 1'b0);
    check("mr_ready", req_ready, 1'b1);
    @(posedge pclk); #2;
    presetn = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      if (resp_valid) rv_cnt++;
    end
    check("mr_no_resp", rv_cnt, 0);
    check("mr_ready_after", req_ready, 1'b1);

    // Randomized traffic, checked by the every-cycle compare process.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 99) < 70);
      req_write = $urandom_range(0, 1);
      req_addr  = $urandom;
      req_wdata = $urandom;
      pready    = ($urandom_range(0, 99) < 40);
      prdata    = $urandom;
      pslverr   = ($urandom_range(0, 99) < 20);
      @(posedge pclk); #1;
    end
    req_valid = 1'b0;
    pready = 1'b1;
    repeat (10) @(posedge pclk);
    #1;
    check("final_idle", req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
